serializador_piso: RTL

Parallel-in / serial-out serializer that sits directly upstream of the 4-bit serial-in shift register (ejercicio2) and drives its serial_in input. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first. Each bit is held for DIV clock cycles, and a one-cycle strobe marks the sample point. It signals completion so the next word can be queued.

---
 rtl/serializador_piso_pkg.sv | 19 +
 rtl/serializador_piso_bit_timer.sv | 33 +++
 rtl/serializador_piso.sv | 88 ++++++++
 3 files changed

// File: rtl/serializador_piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding, default sizes
// and the counter-width helper.
package serializador_piso_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DIV   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter width that is never zero, even when only one value is needed
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializador_piso_bit_timer.sv
// Bit-period down-counter: loads DIV-1, counts down while enabled and flags
// a tick whenever the count sits at zero (last cycle of a bit period).
module serializador_piso_bit_timer
    import serializador_piso_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Reload has priority; the count parks at zero and never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/serializador_piso.sv
// Parallel-in / serial-out serializer, MSB first, each bit held DIV cycles
// with a strobe on the last cycle of every bit period.
module serializador_piso
    import serializador_piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bit_cnt;
    logic             w_handshake;
    logic             w_tick;
    logic             w_advance;
    logic             w_timer_load;

    assign w_handshake  = load_valid && (r_state == ST_IDLE);
    // Move to the next bit only at the end of a period that is not the last
    assign w_advance    = (r_state == ST_SHIFT) && w_tick && (r_bit_cnt != '0);
    assign w_timer_load = w_handshake || w_advance;

    serializador_piso_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_timer_load),
        .i_en   (r_state == ST_SHIFT),
        .o_tick (w_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (load_valid) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && (r_bit_cnt == '0)) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Shift register and bit counter: capture on handshake, shift on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_handshake) begin
            r_shreg   <= load_data;
            r_bit_cnt <= LAST_BIT;
        end else if (w_advance) begin
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Outputs decoded purely from registered state
    assign load_ready = (r_state == ST_IDLE);
    assign serial_out = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
    assign bit_strobe = (r_state == ST_SHIFT) && w_tick;
    assign busy       = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);

endmodule
